// File: rtl/b4to2_pending_encoder_pkg.sv
// Shared constants and state encoding for the pending-request encoder.
// Optional round-robin selection is enabled by defining B4TO2_ROUND_ROBIN_EN.
package b4to2_pending_encoder_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

endpackage : b4to2_pending_encoder_pkg

// File: rtl/b4to2_pending_encoder_prio.sv
// Combinational priority encoder: finds the first set bit of vector scanning
// upward from index start with wrap-around.
module b4to2_prio_encoder
   import b4to2_pending_encoder_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic [N-1:0] vector,
   input  logic [W-1:0] start,
   output logic [W-1:0] index,
   output logic         found
);

   logic [W-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      index = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = start + W'(i);
         if (vector[idx]) begin
            index = idx;
            found = 1'b1;
         end
      end
   end

endmodule : b4to2_prio_encoder

// File: rtl/b4to2_pending_encoder.sv
// Buffers request pulses into a pending vector and offers one index at a time
// over valid/ready. Define B4TO2_ROUND_ROBIN_EN for rotating priority.
module b4to2_pending_encoder
   import b4to2_pending_encoder_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] x3_x0,
   output logic [W-1:0] z1_z0,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pend
);

   // Handshake: z1_z0 is transferred on a rising edge where valid and ready
   // are both 1; z1_z0 is stable while valid=1 and ready=0; ready is ignored
   // while valid=0.

   state_e       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] z_q, z_d;

   logic         hs;
   logic [N-1:0] served;
   logic [N-1:0] rem;
   logic [W-1:0] start;
   logic [W-1:0] sel_index;
   logic         sel_found;

   assign valid = (state_q == OFFER);
   assign z1_z0 = z_q;
   assign pend  = pend_q;

   always_comb begin
      hs     = valid & ready;
      served = '0;
      if (hs) begin
         served[z_q] = 1'b1;
      end
      rem    = pend_q & ~served;
      pend_d = rem | x3_x0;
   end

`ifdef B4TO2_ROUND_ROBIN_EN
   logic [W-1:0] ptr_q, ptr_d;

   // The scan after a handshake starts just past the index being served now.
   always_comb begin
      ptr_d = hs ? z_q : ptr_q;
      start = ptr_d + W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '1;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign start = '0;
`endif

   // In IDLE nothing is served, so rem equals the pending vector.
   b4to2_prio_encoder #(
      .N (N),
      .W (W)
   ) u_prio (
      .vector (rem),
      .start  (start),
      .index  (sel_index),
      .found  (sel_found)
   );

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               z_d     = sel_index;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (hs) begin
               if (sel_found) begin
                  z_d = sel_index;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         z_q     <= z_d;
      end
   end

endmodule : b4to2_pending_encoder

// File: tb/tb_b4to2_pending_encoder.sv
// Directed bench for b4to2_pending_encoder; expectations follow
// B4TO2_ROUND_ROBIN_EN where the priority order matters.
module tb_b4to2_pending_encoder;

   localparam int N = 4;
   localparam int W = 2;

   logic         clock;
   logic         reset;
   logic [N-1:0] x3_x0;
   logic [W-1:0] z1_z0;
   logic         valid;
   logic         ready;
   logic [N-1:0] pend;

   int checks;
   int failures;

   b4to2_pending_encoder #(
      .N (N),
      .W (W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .x3_x0 (x3_x0),
      .z1_z0 (z1_z0),
      .valid (valid),
      .ready (ready),
      .pend  (pend)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      x3_x0 = 4'b1111;
      ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      x3_x0 = 4'b0000;
      ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (pend !== 4'b0000) begin
         failures++;
         $display("FAIL reset_pend got=%b exp=0000", pend);
      end
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=0", valid);
      end
      checks++;
      if (z1_z0 !== 2'd0) begin
         failures++;
         $display("FAIL reset_z got=%0d exp=0", z1_z0);
      end
      step();
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle valid=%b pend=%b exp valid=0 pend=0000", valid, pend);
      end
   endtask

   task automatic test_single();
      apply_reset();
      x3_x0 = 4'b0100;
      ready = 1'b1;
      step();
      x3_x0 = 4'b0000;
      checks++;
      if (pend !== 4'b0100 || valid !== 1'b0) begin
         failures++;
         $display("FAIL single_latch pend=%b valid=%b exp pend=0100 valid=0", pend, valid);
      end
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd2) begin
         failures++;
         $display("FAIL single_offer valid=%b z=%0d exp valid=1 z=2", valid, z1_z0);
      end
      step();
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000) begin
         failures++;
         $display("FAIL single_done valid=%b pend=%b exp valid=0 pend=0000", valid, pend);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_seq [3];
      exp_seq = '{2'd0, 2'd1, 2'd3};
      apply_reset();
      x3_x0 = 4'b1011;
      ready = 1'b1;
      step();
      x3_x0 = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (valid !== 1'b1 || z1_z0 !== exp_seq[i]) begin
            failures++;
            $display("FAIL b2b_seq%0d valid=%b z=%0d exp valid=1 z=%0d", i, valid, z1_z0, exp_seq[i]);
         end
      end
      step();
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000) begin
         failures++;
         $display("FAIL b2b_done valid=%b pend=%b exp valid=0 pend=0000", valid, pend);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      x3_x0 = 4'b1000;
      ready = 1'b0;
      step();
      x3_x0 = 4'b0000;
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd3) begin
         failures++;
         $display("FAIL stall_offer valid=%b z=%0d exp valid=1 z=3", valid, z1_z0);
      end
      x3_x0 = 4'b0001;
      step();
      x3_x0 = 4'b0000;
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd3 || pend !== 4'b1001) begin
         failures++;
         $display("FAIL stall_hold valid=%b z=%0d pend=%b exp valid=1 z=3 pend=1001", valid, z1_z0, pend);
      end
      step();
      checks++;
      if (z1_z0 !== 2'd3) begin
         failures++;
         $display("FAIL stall_hold2 z=%0d exp=3", z1_z0);
      end
      ready = 1'b1;
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd0 || pend !== 4'b0001) begin
         failures++;
         $display("FAIL stall_next valid=%b z=%0d pend=%b exp valid=1 z=0 pend=0001", valid, z1_z0, pend);
      end
      step();
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000) begin
         failures++;
         $display("FAIL stall_done valid=%b pend=%b exp valid=0 pend=0000", valid, pend);
      end
   endtask

   task automatic test_set_wins();
      apply_reset();
      x3_x0 = 4'b0010;
      ready = 1'b0;
      step();
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd1) begin
         failures++;
         $display("FAIL setwin_offer valid=%b z=%0d exp valid=1 z=1", valid, z1_z0);
      end
      ready = 1'b1;
      step();
      x3_x0 = 4'b0000;
      checks++;
      if (pend !== 4'b0010 || valid !== 1'b0) begin
         failures++;
         $display("FAIL setwin_keep pend=%b valid=%b exp pend=0010 valid=0", pend, valid);
      end
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd1) begin
         failures++;
         $display("FAIL setwin_reoffer valid=%b z=%0d exp valid=1 z=1", valid, z1_z0);
      end
      step();
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000) begin
         failures++;
         $display("FAIL setwin_done valid=%b pend=%b exp valid=0 pend=0000", valid, pend);
      end
   endtask

   task automatic test_priority_order();
      logic [W-1:0] exp_first;
      logic [W-1:0] exp_second;
`ifdef B4TO2_ROUND_ROBIN_EN
      exp_first  = 2'd1;
      exp_second = 2'd0;
`else
      exp_first  = 2'd0;
      exp_second = 2'd1;
`endif
      apply_reset();
      x3_x0 = 4'b0001;
      ready = 1'b0;
      step();
      x3_x0 = 4'b0000;
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== 2'd0) begin
         failures++;
         $display("FAIL prio_first0 valid=%b z=%0d exp valid=1 z=0", valid, z1_z0);
      end
      ready = 1'b1;
      x3_x0 = 4'b0011;
      step();
      x3_x0 = 4'b0000;
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0011) begin
         failures++;
         $display("FAIL prio_pend valid=%b pend=%b exp valid=0 pend=0011", valid, pend);
      end
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== exp_first) begin
         failures++;
         $display("FAIL prio_a valid=%b z=%0d exp valid=1 z=%0d", valid, z1_z0, exp_first);
      end
      step();
      checks++;
      if (valid !== 1'b1 || z1_z0 !== exp_second) begin
         failures++;
         $display("FAIL prio_b valid=%b z=%0d exp valid=1 z=%0d", valid, z1_z0, exp_second);
      end
      step();
      checks++;
      if (valid !== 1'b0 || pend !== 4'b0000) begin
         failures++;
         $display("FAIL prio_done valid=%b pend=%b exp valid=0 pend=0000", valid, pend);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      x3_x0    = '0;
      ready    = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_set_wins();
      test_priority_order();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_b4to2_pending_encoder
